// File: rtl/scff_bist_pkg.sv
// Shared constants for the scan-chain BIST: FSM state encoding and default chain geometry,
// also used by fabric testbenches.
package scff_bist_pkg;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] FLUSH    = 3'd1;
  localparam logic [2:0] INJECT   = 3'd2;
  localparam logic [2:0] SHIFT    = 3'd3;
  localparam logic [2:0] CHECK_LO = 3'd4;
  localparam logic [2:0] DONE     = 3'd5;

  localparam int DEF_SCANCHAIN_SIZE = 2304;
  localparam int DEF_GUARD          = 2;
  localparam int DEF_ERR_W          = 8;

  // One counter serves both the chain-length phases and the guard phase.
  function automatic int cntWidth(input int n, input int g);
    int m;
    m = (n > g) ? n : g;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/scff_sat_counter.sv
// Increment-enable counter with synchronous clear that sticks at all-ones instead of wrapping.
module scff_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         i_clear,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (i_clear) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/scff_chain_bist.sv
// Scan-chain BIST: flushes the chain, injects a single '1', and checks that it emerges at the
// tail exactly SCANCHAIN_SIZE cycles later followed by GUARD quiet cycles.
module scff_chain_bist
  import scff_bist_pkg::*;
#(
  parameter int SCANCHAIN_SIZE = DEF_SCANCHAIN_SIZE,
  parameter int GUARD          = DEF_GUARD,
  parameter int ERR_W          = DEF_ERR_W
) (
  input  logic             clk,
  input  logic             greset,
  input  logic             start,
  output logic             Test_en,
  output logic             sc_head,
  input  logic             sc_tail,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count
);

  localparam int CW = cntWidth(SCANCHAIN_SIZE, GUARD);
  localparam logic [CW-1:0] LAST_N = CW'(SCANCHAIN_SIZE - 1);
  localparam logic [CW-1:0] LAST_G = CW'(GUARD - 1);

  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          w_startOk;
  logic          w_errInc;
  logic          w_errClear;

  assign w_startOk = start && ((r_state == IDLE) || (r_state == DONE));

  always_ff @(posedge clk) begin
    if (greset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_startOk) begin
            r_state <= FLUSH;
            r_cnt   <= '0;
          end
        end
        FLUSH: begin
          if (r_cnt == LAST_N) begin
            r_state <= INJECT;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        INJECT: begin
          r_state <= SHIFT;
          r_cnt   <= '0;
        end
        SHIFT: begin
          if (r_cnt == LAST_N) begin
            r_state <= CHECK_LO;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        CHECK_LO: begin
          if (r_cnt == LAST_G) begin
            r_state <= DONE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // In SHIFT the tail must be 1 only on the last count; a 1 earlier is early, a 0 then is a miss.
  always_comb begin
    w_errInc = 1'b0;
    if (r_state == SHIFT) begin
      w_errInc = (r_cnt == LAST_N) ? !sc_tail : sc_tail;
    end else if (r_state == CHECK_LO) begin
      w_errInc = sc_tail;
    end
  end

  assign w_errClear = greset || w_startOk;

  scff_sat_counter #(
    .W(ERR_W)
  ) u_errCounter (
    .clk     (clk),
    .i_clear (w_errClear),
    .i_inc   (w_errInc),
    .o_count (err_count)
  );

  assign busy    = (r_state == FLUSH) || (r_state == INJECT) ||
                   (r_state == SHIFT) || (r_state == CHECK_LO);
  assign Test_en = busy;
  assign sc_head = (r_state == INJECT);
  assign done    = (r_state == DONE);
  assign pass    = done && (err_count == '0);

endmodule

// File: tb/tb_scff_chain_bist.sv
// Scoreboard bench for scff_chain_bist with behavioural scan chains on three instances
// (N=8/ERR_W=8, N=8/ERR_W=2 with stuck tail, N=1/GUARD=1).
module tb_scff_chain_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic greset;
  logic startA, startB, startC;

  logic       testEnA, headA, tailA, busyA, doneA, passA;
  logic [7:0] errA;
  logic       testEnB, headB, busyB, doneB, passB;
  logic [1:0] errB;
  logic       testEnC, headC, tailC, busyC, doneC, passC;
  logic [7:0] errC;

  logic [7:0] chainA = '0;
  logic       chainC = 1'b0;
  int         lenA   = 8;
  bit         stuckA = 1'b0;

  always @(posedge clk) if (testEnA) chainA <= {chainA[6:0], headA};
  always @(posedge clk) if (testEnC) chainC <= headC;
  assign tailA = stuckA ? 1'b1 : chainA[lenA-1];
  assign tailC = chainC;

  scff_chain_bist #(.SCANCHAIN_SIZE(8), .GUARD(2), .ERR_W(8)) dutA (
    .clk(clk), .greset(greset), .start(startA), .Test_en(testEnA), .sc_head(headA),
    .sc_tail(tailA), .busy(busyA), .done(doneA), .pass(passA), .err_count(errA));

  scff_chain_bist #(.SCANCHAIN_SIZE(8), .GUARD(2), .ERR_W(2)) dutB (
    .clk(clk), .greset(greset), .start(startB), .Test_en(testEnB), .sc_head(headB),
    .sc_tail(1'b1), .busy(busyB), .done(doneB), .pass(passB), .err_count(errB));

  scff_chain_bist #(.SCANCHAIN_SIZE(1), .GUARD(1), .ERR_W(8)) dutC (
    .clk(clk), .greset(greset), .start(startC), .Test_en(testEnC), .sc_head(headC),
    .sc_tail(tailC), .busy(busyC), .done(doneC), .pass(passC), .err_count(errC));

  typedef struct {
    string tag;
    int    lat;
    int    err;
    int    pass;
    int    headCyc;
    int    tailCyc;
    bit    checkTail;
  } exp_t;

  exp_t sb[$];
  int   vecCount  = 0;
  int   missCount = 0;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic setStart(input int sel, input logic v);
    case (sel)
      0: startA = v;
      1: startB = v;
      default: startC = v;
    endcase
  endtask

  function automatic logic doneOf(input int sel);
    case (sel)
      0: return doneA;
      1: return doneB;
      default: return doneC;
    endcase
  endfunction

  function automatic logic headOf(input int sel);
    case (sel)
      0: return headA;
      1: return headB;
      default: return headC;
    endcase
  endfunction

  function automatic logic tailOf(input int sel);
    case (sel)
      0: return tailA;
      1: return 1'b1;
      default: return tailC;
    endcase
  endfunction

  function automatic int errOf(input int sel);
    case (sel)
      0: return int'(errA);
      1: return int'(errB);
      default: return int'(errC);
    endcase
  endfunction

  function automatic int passOf(input int sel);
    case (sel)
      0: return int'(passA);
      1: return int'(passB);
      default: return int'(passC);
    endcase
  endfunction

  function automatic int busyOf(input int sel);
    case (sel)
      0: return int'(busyA);
      1: return int'(busyB);
      default: return int'(busyC);
    endcase
  endfunction

  // Push the expected outcome of one run, drive it, then pop and compare once done rises.
  task automatic applyStimulus(input int sel, input string tag, input int expErr,
                               input int expPass, input bit checkTail, input int extraStartAt);
    int   n, g, cycles, headCnt, headCyc, tailCnt, tailCyc;
    exp_t e;
    n = (sel == 2) ? 1 : 8;
    g = (sel == 2) ? 1 : 2;
    sb.push_back('{tag, 1 + n + 1 + n + g, expErr, expPass, n + 1, 2 * n + 1, checkTail});
    headCnt = 0; headCyc = -1; tailCnt = 0; tailCyc = -1;
    setStart(sel, 1'b1);
    @(negedge clk);
    setStart(sel, 1'b0);
    cycles = 1;
    while (!doneOf(sel) && cycles < 200) begin
      if (headOf(sel)) begin headCnt++; headCyc = cycles; end
      if (tailOf(sel) && cycles > n + 1) begin tailCnt++; tailCyc = cycles; end
      setStart(sel, cycles == extraStartAt);
      @(negedge clk);
      cycles++;
    end
    setStart(sel, 1'b0);
    e = sb.pop_front();
    checkOutput({e.tag, " latency"}, cycles, e.lat);
    checkOutput({e.tag, " err_count"}, errOf(sel), e.err);
    checkOutput({e.tag, " pass"}, passOf(sel), e.pass);
    checkOutput({e.tag, " busy"}, busyOf(sel), 0);
    checkOutput({e.tag, " head pulses"}, headCnt, 1);
    checkOutput({e.tag, " head cycle"}, headCyc, e.headCyc);
    if (e.checkTail) begin
      checkOutput({e.tag, " tail pulses"}, tailCnt, 1);
      checkOutput({e.tag, " tail cycle"}, tailCyc, e.tailCyc);
    end
  endtask

  initial begin
    greset = 1'b1;
    startA = 1'b0; startB = 1'b0; startC = 1'b0;
    repeat (2) @(negedge clk);
    greset = 1'b0;
    @(negedge clk);
    checkOutput("reset Test_en", int'(testEnA), 0);
    checkOutput("reset sc_head", int'(headA), 0);
    checkOutput("reset busy", int'(busyA), 0);
    checkOutput("reset done", int'(doneA), 0);
    checkOutput("reset pass", int'(passA), 0);
    checkOutput("reset err_count", int'(errA), 0);

    applyStimulus(0, "healthy", 0, 1, 1'b1, -1);

    lenA = 7;
    applyStimulus(0, "short chain", 2, 0, 1'b0, -1);
    lenA = 8;

    stuckA = 1'b1;
    applyStimulus(0, "stuck tail", 9, 0, 1'b0, -1);
    stuckA = 1'b0;
    checkOutput("done held", int'(doneA), 1);

    applyStimulus(0, "restart from done", 0, 1, 1'b1, -1);
    applyStimulus(0, "start in flush", 0, 1, 1'b1, 3);

    // Reset mid-SHIFT with errors already accumulated
    stuckA = 1'b1;
    startA = 1'b1;
    @(negedge clk);
    startA = 1'b0;
    repeat (13) @(negedge clk);
    checkOutput("mid-shift err before reset", int'(errA), 4);
    greset = 1'b1;
    @(negedge clk);
    greset = 1'b0;
    stuckA = 1'b0;
    checkOutput("mid reset Test_en", int'(testEnA), 0);
    checkOutput("mid reset sc_head", int'(headA), 0);
    checkOutput("mid reset busy", int'(busyA), 0);
    checkOutput("mid reset done", int'(doneA), 0);
    checkOutput("mid reset err_count", int'(errA), 0);
    applyStimulus(0, "after reset", 0, 1, 1'b1, -1);

    applyStimulus(1, "saturate", 3, 0, 1'b0, -1);
    applyStimulus(2, "N1 G1", 0, 1, 1'b1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
